// File: rtl/kv32_boot_loader.sv
// Framed-byte-stream boot loader: parses MAGIC/ADDR/LEN/DATA/CSUM frames into imem word writes
// and holds the core in reset until a frame with a good checksum has been loaded.
module kv32_boot_loader #(
    parameter int          MEM_BYTES = 16384,
    parameter int          ADDR_W    = 12,
    parameter logic [7:0]  MAGIC     = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [3:0]        imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_din,
    output logic              core_rst,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t              r_state, w_state_next;
    logic                r_ready;
    logic [1:0]          r_cnt;
    logic [31:0]         r_addr;
    logic [23:0]         r_len;
    logic [31:0]         r_remain;
    logic [ADDR_W+1:0]   r_ptr;
    logic [7:0]          r_sum;
    logic [31:0]         r_buf;
    logic [3:0]          r_mask;

    logic                w_acc;
    logic                w_magic;
    logic [31:0]         w_len_full;
    logic [32:0]         w_end;
    logic                w_range_bad;
    logic [1:0]          w_lane;
    logic [31:0]         w_buf_next;
    logic [3:0]          w_mask_next;
    logic                w_last;
    logic [7:0]          w_sum_next;

    // Handshake: a byte transfers on a rising edge where s_tvalid && s_tready; s_tready never drops after reset.
    assign s_tready    = r_ready;
    assign w_acc       = s_tvalid && r_ready;
    assign w_magic     = (s_tdata == MAGIC);
    assign w_len_full  = {s_tdata, r_len};
    assign w_end       = {1'b0, r_addr} + {1'b0, w_len_full};
    assign w_range_bad = (w_end > 33'(MEM_BYTES));
    assign w_lane      = r_ptr[1:0];
    assign w_buf_next  = r_buf | ({24'b0, s_tdata} << {w_lane, 3'b000});
    assign w_mask_next = r_mask | (4'b0001 << w_lane);
    assign w_last      = (r_remain == 32'd1);
    assign w_sum_next  = r_sum + s_tdata;
    assign dbg_state   = r_state;

    always_comb begin
        w_state_next = r_state;
        if (w_acc) begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: if (w_magic) w_state_next = S_ADDR;
                S_ADDR: if (r_cnt == 2'd3) w_state_next = S_LEN;
                S_LEN: begin
                    if (r_cnt == 2'd3) begin
                        if (w_range_bad)              w_state_next = S_ERR;
                        else if (w_len_full == 32'd0) w_state_next = S_CSUM;
                        else                          w_state_next = S_DATA;
                    end
                end
                S_DATA: if (w_last) w_state_next = S_CSUM;
                S_CSUM: w_state_next = (w_sum_next == 8'd0) ? S_DONE : S_ERR;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready   <= 1'b0;
            r_cnt     <= 2'd0;
            r_addr    <= 32'd0;
            r_len     <= 24'd0;
            r_remain  <= 32'd0;
            r_ptr     <= '0;
            r_sum     <= 8'd0;
            r_buf     <= 32'd0;
            r_mask    <= 4'd0;
            imem_we   <= 4'd0;
            imem_addr <= '0;
            imem_din  <= 32'd0;
            core_rst  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            imem_we <= 4'd0;
            if (w_acc) begin
                case (r_state)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (w_magic) begin
                            core_rst <= 1'b1;
                            done     <= 1'b0;
                            err      <= 1'b0;
                            r_cnt    <= 2'd0;
                            r_sum    <= 8'd0;
                            r_buf    <= 32'd0;
                            r_mask   <= 4'd0;
                        end
                    end
                    S_ADDR: begin
                        r_addr <= {s_tdata, r_addr[31:8]};
                        r_cnt  <= r_cnt + 2'd1;
                    end
                    S_LEN: begin
                        r_len <= {s_tdata, r_len[23:8]};
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_ptr    <= r_addr[ADDR_W+1:0];
                            r_remain <= w_len_full;
                            if (w_range_bad) err <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        r_ptr    <= r_ptr + 1'b1;
                        r_remain <= r_remain - 32'd1;
                        r_sum    <= w_sum_next;
                        // Word complete or frame ends: emit the partial word, restart the buffer.
                        if (w_lane == 2'd3 || w_last) begin
                            imem_we   <= w_mask_next;
                            imem_din  <= w_buf_next;
                            imem_addr <= r_ptr[ADDR_W+1:2];
                            r_buf     <= 32'd0;
                            r_mask    <= 4'd0;
                        end else begin
                            r_buf  <= w_buf_next;
                            r_mask <= w_mask_next;
                        end
                    end
                    S_CSUM: begin
                        if (w_sum_next == 8'd0) begin
                            done     <= 1'b1;
                            core_rst <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_kv32_boot_loader.sv
// Self-checking bench for kv32_boot_loader: directed scenarios plus random frames, scoreboarded writes.
`timescale 1ns/1ps
module tb_kv32_boot_loader;

    localparam int MEM_BYTES = 16384;
    localparam int ADDR_W    = 12;
    localparam int W         = ADDR_W + 4 + 32;

    logic              clk;
    logic              rst_n;
    logic [7:0]        s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic [3:0]        imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_din;
    logic              core_rst;
    logic              done;
    logic              err;
    logic [2:0]        dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0]   data_q[$];

    kv32_boot_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W), .MAGIC(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_din(imem_din),
        .core_rst(core_rst), .done(done), .err(err), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // monitor: every nonzero imem_we must match the head of the expected queue
    logic [W-1:0] mon_exp;
    always @(negedge clk) begin
        if (rst_n && imem_we != 4'd0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h/%0h/%0h required=none", imem_addr, imem_we, imem_din);
            end else begin
                mon_exp = exp_q.pop_front();
                check("write", {imem_addr, imem_we, imem_din}, mon_exp);
            end
        end
    end

    // driver
    task automatic send_byte(input logic [7:0] b, input int gmax);
        int g;
        int n;
        g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
        repeat (g) begin @(posedge clk); #1; end
        s_tdata  = b;
        s_tvalid = 1'b1;
        n = 0;
        while (!s_tready && n < 1000) begin @(posedge clk); #1; n++; end
        if (!s_tready) begin
            checks++;
            failures++;
            $display("FAIL tready_timeout actual=0 required=1");
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tdata  = $urandom_range(255, 0);
    endtask

    function automatic logic [7:0] data_sum(input int n);
        logic [7:0] s = 8'd0;
        for (int i = 0; i < n; i++) s = s + data_q[i];
        return s;
    endfunction

    // reference model: group consecutive payload bytes by word address
    task automatic model_frame(input logic [31:0] addr, input logic [31:0] len, input logic [7:0] csum,
                               output bit exp_done, output bit exp_err);
        longint unsigned end_a;
        longint unsigned a;
        longint unsigned cur_w;
        logic [3:0]  cur_m;
        logic [31:0] cur_d;
        logic [7:0]  sum;
        end_a = longint'(addr) + longint'(len);
        exp_done = 1'b0;
        exp_err  = 1'b1;
        if (end_a > MEM_BYTES) return;
        cur_w = 0; cur_m = 4'd0; cur_d = 32'd0; sum = 8'd0;
        for (int i = 0; i < int'(len); i++) begin
            a = longint'(addr) + i;
            if (cur_m != 4'd0 && (a / 4) != cur_w) begin
                exp_q.push_back({cur_w[ADDR_W-1:0], cur_m, cur_d});
                cur_m = 4'd0; cur_d = 32'd0;
            end
            cur_w = a / 4;
            cur_m[a % 4] = 1'b1;
            cur_d[(a % 4) * 8 +: 8] = data_q[i];
            sum = sum + data_q[i];
        end
        if (cur_m != 4'd0) exp_q.push_back({cur_w[ADDR_W-1:0], cur_m, cur_d});
        exp_done = ((sum + csum) & 8'hFF) == 8'd0;
        exp_err  = !exp_done;
    endtask

    task automatic frame(input logic [31:0] addr, input logic [31:0] len, input logic [7:0] csum, input int gmax);
        bit exp_done, exp_err;
        bit range_bad;
        range_bad = (longint'(addr) + longint'(len)) > MEM_BYTES;
        model_frame(addr, len, csum, exp_done, exp_err);
        send_byte(8'hA5, gmax);
        for (int i = 0; i < 4; i++) send_byte(addr[i*8 +: 8], gmax);
        for (int i = 0; i < 4; i++) send_byte(len[i*8 +: 8], gmax);
        if (range_bad) begin
            @(negedge clk);
            check("range_err_timing", err, 1'b1);
            @(posedge clk); #1;
        end
        for (int i = 0; i < data_q.size(); i++) send_byte(data_q[i], gmax);
        send_byte(csum, gmax);
        @(negedge clk);
        check("done", done, exp_done);
        check("err", err, exp_err);
        check("core_rst", core_rst, !exp_done);
        repeat (3) @(negedge clk);
        check("writes_drained", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values();
        check("rst_tready", s_tready, 1'b0);
        check("rst_we", imem_we, 4'd0);
        check("rst_addr", imem_addr, 0);
        check("rst_din", imem_din, 32'd0);
        check("rst_core_rst", core_rst, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
    endtask

    function automatic logic [7:0] non_magic();
        logic [7:0] b;
        b = $urandom_range(255, 0);
        if (b == 8'hA5) b = 8'h5A;
        return b;
    endfunction

    logic [31:0] r_addr_v, r_len_v;
    logic [7:0]  r_cs;

    initial begin
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: aligned
        data_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        frame(32'd0, 32'd8, 8'h4A, 0);
        // 2: unaligned
        data_q = '{8'hAA, 8'hBB, 8'hCC};
        frame(32'd2, 32'd3, 8'hCF, 0);
        // 3: bad checksum
        data_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        frame(32'd0, 32'd8, 8'h4B, 0);
        // 4: range error, then trailing bytes ignored
        data_q = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
        frame(32'h3FFC, 32'd8, 8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h5A, 0);
        @(negedge clk);
        check("err_holds", err, 1'b1);
        check("done_low_after_err", done, 1'b0);
        @(posedge clk); #1;
        // boundary: ends exactly at MEM_BYTES
        data_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        frame(32'h3FFC, 32'd4, 8'hF6, 0);
        // 5: garbage, empty frame, restart
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h5A, 0);
        data_q = {};
        frame(32'd0, 32'd0, 8'h00, 0);
        send_byte(8'hA5, 0);
        @(negedge clk);
        check("restart_core_rst", core_rst, 1'b1);
        check("restart_done", done, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) send_byte(8'h00, 0);
        @(negedge clk);
        check("empty_done", done, 1'b1);
        @(posedge clk); #1;
        // 6: gaps
        data_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        frame(32'd0, 32'd8, 8'h4A, 4);
        // 6: mid-frame reset after 2nd data byte
        send_byte(8'hA5, 0);
        for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
        send_byte(8'h08, 0);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        frame(32'd0, 32'd8, 8'h4A, 0);

        // random frames
        for (int f = 0; f < 25; f++) begin
            data_q = {};
            if ($urandom_range(7, 0) == 0) begin
                r_addr_v = MEM_BYTES - $urandom_range(3, 0);
                r_len_v  = 32'd8;
                for (int i = 0; i < 8; i++) data_q.push_back(non_magic());
                r_cs = non_magic();
            end else begin
                r_addr_v = ($urandom_range(1, 0) == 1) ? $urandom_range(64, 0)
                                                       : MEM_BYTES - 16 + $urandom_range(4, 0);
                r_len_v  = $urandom_range(12, 0);
                for (int i = 0; i < int'(r_len_v); i++) data_q.push_back($urandom_range(255, 0));
                r_cs = 8'd0 - data_sum(int'(r_len_v));
                if ($urandom_range(3, 0) == 0) r_cs = r_cs + 8'd1;
            end
            frame(r_addr_v, r_len_v, r_cs, $urandom_range(2, 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kv32_boot_loader.md
Name: kv32_boot_loader

Overview:
- Upstream feeder of the kv32_top instruction memory.
- Parses a framed byte stream (UART receiver or bench driver) and packs the payload bytes into 32-bit word writes with byte enables on the imem write port.
- Holds the core in reset until a frame with a valid checksum completes.
- Replaces the hierarchical hex preload for silicon/FPGA boot.

Parameters:
- MEM_BYTES, 16384: imem size in bytes; multiple of 4.
- ADDR_W, 12: imem word-address width; equals clog2(MEM_BYTES/4).
- MAGIC, 8'hA5: frame start byte.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- s_tdata  in  8  stream byte
- s_tvalid  in  1  byte valid
- s_tready  out  1  byte accepted when s_tvalid && s_tready
- imem_we  out  4  byte-lane write enables; lane i = din[8i+7:8i]
- imem_addr  out  ADDR_W  word address
- imem_din  out  32  write data
- core_rst  out  1  active-high reset to kv32_top core
- done  out  1  last frame loaded OK
- err  out  1  last frame failed

Behaviour:
- Reset values:
  - s_tready=0, imem_we=0, imem_addr=0, imem_din=0.
  - core_rst=1, done=0, err=0.
  - State IDLE; all accumulators cleared.
- s_tready=1 in every state once rst_n is high. No backpressure; the imem write port is fire-and-forget.
- Frame format: MAGIC, ADDR[4] little-endian byte address, LEN[4] little-endian, LEN data bytes, CSUM[1]. The frame is valid when the 8-bit sum of the data bytes plus CSUM equals 0x00.
- States:
  - IDLE: discard non-MAGIC bytes. On MAGIC: go to ADDR, core_rst=1, done=0, err=0.
  - ADDR: collect 4 bytes, then go to LEN.
  - LEN: collect 4 bytes. On the 4th byte, compute ADDR+LEN at 33-bit width.
    - If the result exceeds MEM_BYTES: go to ERR; no writes are issued.
    - Else if LEN=0: go to CSUM.
    - Else: go to DATA.
  - DATA: each accepted byte goes into word buffer lane ptr[1:0] at word ptr[ADDR_W+1:2]. ptr starts at ADDR and increments per byte. Decrement the remaining count and accumulate the sum. After the LEN-th byte, go to CSUM.
  - CSUM: on the accepted byte, check the sum.
    - Pass: go to DONE, done=1, core_rst=0 in the cycle after acceptance.
    - Fail: go to ERR, err=1, core_rst stays 1.
  - DONE / ERR: wait for MAGIC, treated as in IDLE. Restarting re-asserts core_rst and clears done/err in the cycle after the MAGIC byte.
- Write flush: a registered write is issued in the cycle after a byte that fills lane 3, or after the LEN-th data byte.
  - imem_we = mask of lanes filled for that word since the last flush.
  - Unfilled lanes of imem_din = 0.
  - imem_we returns to 0 the following cycle unless another flush is due.
- Back-to-back: a flush and a byte accepted into the next word in the same cycle are legal. The buffer and mask restart with the new byte; no byte is lost.
- s_tvalid gaps are allowed in any state; they do not affect the result.
- Data writes are not rolled back on a checksum failure. core_rst staying asserted is the protection.
- Reset mid-frame: immediate return to reset values. A partially accumulated word is dropped, not written.

Test Plan:
1. Aligned frame, ADDR=0:
   - Stimulus: A5 00 00 00 00 08 00 00 00 13 00 00 00 93 00 10 00 4A.
   - Required: addr0 we=1111 din=00000013; addr1 we=1111 din=00100093; then done=1, core_rst=0, err=0.
2. Unaligned frame:
   - Stimulus: ADDR=2, LEN=3, data AA BB CC, CSUM=CF.
   - Required: addr0 we=1100 din=BBAA0000; addr1 we=0001 din=000000CC; then done=1.
3. Bad checksum:
   - Stimulus: scenario 1 with CSUM=4B.
   - Required: both writes still issued; err=1, done=0, core_rst remains 1.
4. Range error:
   - Stimulus: MEM_BYTES=16384, ADDR=0x3FFC, LEN=8.
   - Required: err=1 the cycle after the last LEN byte; zero writes; following bytes are ignored until A5.
5. Leading garbage and empty frame:
   - Stimulus: 00 FF 5A, then A5, ADDR=0, LEN=0, CSUM=00.
   - Required: no writes, done=1, core_rst=0.
   - Follow-up: a second A5 re-asserts core_rst.
6. Gaps and mid-frame reset:
   - Stimulus: scenario 1 with random idle cycles between bytes.
   - Required: identical write sequence.
   - Stimulus: rst_n pulsed low after the 2nd data byte.
   - Required: all outputs at reset values, no write issued; the following full frame loads correctly.
